// File: rtl/regbus_pkg.sv
// Shared types and sizing helpers for the register-bus round-robin arbiter.
package regbus_pkg;

    localparam int unsigned ADDR_W_DEF = 3;
    localparam int unsigned DATA_W_DEF = 2;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} regbus_state_e;

    // Width of an index able to address n entries (at least one bit).
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/regbus_rr_arbiter_rr_pick.sv
// Combinational round-robin picker: first asserted request at or after ptr, wrapping.
module rr_pick
    import regbus_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned IDX_W   = idx_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] grant_c,
    output logic [IDX_W-1:0]   idx_c,
    output logic               any_c
);

    always_comb begin
        int unsigned j;
        grant_c = '0;
        idx_c   = '0;
        any_c   = 1'b0;
        j       = 0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            j = (32'(ptr) + i) % NUM_REQ;
            if (!any_c && req[IDX_W'(j)]) begin
                any_c              = 1'b1;
                grant_c[IDX_W'(j)] = 1'b1;
                idx_c              = IDX_W'(j);
            end
        end
    end

endmodule

// File: rtl/regbus_rr_arbiter.sv
// Round-robin arbiter serialising NUM_REQ requesters onto one register-file bus.
// One transaction in flight; read data captured after RD_LAT wait cycles.
module regbus_rr_arbiter
    import regbus_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned ADDR_W  = ADDR_W_DEF,
    parameter int unsigned DATA_W  = DATA_W_DEF,
    parameter int unsigned RD_LAT  = 1
) (
    input  logic                        CLK,
    input  logic                        RST,
    input  logic [NUM_REQ-1:0]          req_valid,
    input  logic [NUM_REQ-1:0]          req_write,
    input  logic [NUM_REQ*ADDR_W-1:0]   req_addr,
    input  logic [NUM_REQ*DATA_W-1:0]   req_wdata,
    output logic [NUM_REQ-1:0]          req_ready,
    output logic [NUM_REQ-1:0]          rsp_valid,
    output logic [DATA_W-1:0]           rsp_rdata,
    output logic                        WRITE,
    output logic                        READ,
    output logic [ADDR_W-1:0]           ADDR,
    output logic [DATA_W-1:0]           WRITE_DATA,
    input  logic [DATA_W-1:0]           READ_DATA,
    output logic                        busy
);

    localparam int unsigned IDX_W = idx_width(NUM_REQ);
    localparam int unsigned CNT_W = idx_width(RD_LAT);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_REQ - 1);
    localparam logic [CNT_W-1:0] WAIT_INIT = CNT_W'(RD_LAT - 1);

    regbus_state_e        state;
    logic [IDX_W-1:0]     ptr;
    logic [IDX_W-1:0]     w_idx;
    logic [NUM_REQ-1:0]   w_oh;
    logic                 w_write;
    logic [CNT_W-1:0]     wait_cnt;

    logic [NUM_REQ-1:0]   pick_grant_c;
    logic [IDX_W-1:0]     pick_idx_c;
    logic                 pick_any_c;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_pick (
        .req     (req_valid),
        .ptr     (ptr),
        .grant_c (pick_grant_c),
        .idx_c   (pick_idx_c),
        .any_c   (pick_any_c)
    );

    // Transaction sequencer; bus strobes and responses are driven from registers only.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state      <= IDLE;
            ptr        <= '0;
            w_idx      <= '0;
            w_oh       <= '0;
            w_write    <= 1'b0;
            wait_cnt   <= '0;
            req_ready  <= '0;
            rsp_valid  <= '0;
            rsp_rdata  <= '0;
            WRITE      <= 1'b0;
            READ       <= 1'b0;
            ADDR       <= '0;
            WRITE_DATA <= '0;
            busy       <= 1'b0;
        end else begin
            req_ready <= '0;
            rsp_valid <= '0;
            case (state)
                IDLE: begin
                    if (pick_any_c) begin
                        w_idx      <= pick_idx_c;
                        w_oh       <= pick_grant_c;
                        w_write    <= req_write[pick_idx_c];
                        req_ready  <= pick_grant_c;
                        ADDR       <= req_addr[pick_idx_c*ADDR_W +: ADDR_W];
                        WRITE_DATA <= req_wdata[pick_idx_c*DATA_W +: DATA_W];
                        WRITE      <= req_write[pick_idx_c];
                        READ       <= !req_write[pick_idx_c];
                        busy       <= 1'b1;
                        state      <= ISSUE;
                    end
                end
                ISSUE: begin
                    WRITE <= 1'b0;
                    READ  <= 1'b0;
                    ptr   <= (w_idx == LAST_IDX) ? '0 : w_idx + IDX_W'(1);
                    if (w_write) begin
                        rsp_valid  <= w_oh;
                        rsp_rdata  <= '0;
                        ADDR       <= '0;
                        WRITE_DATA <= '0;
                        state      <= RESP;
                    end else begin
                        wait_cnt <= WAIT_INIT;
                        state    <= WAIT;
                    end
                end
                WAIT: begin
                    if (wait_cnt == '0) begin
                        rsp_valid  <= w_oh;
                        rsp_rdata  <= READ_DATA;
                        ADDR       <= '0;
                        WRITE_DATA <= '0;
                        state      <= RESP;
                    end else begin
                        wait_cnt <= wait_cnt - CNT_W'(1);
                    end
                end
                RESP: begin
                    rsp_rdata <= '0;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Requester must keep its request up through the accept cycle.
    a_req_held: assert property (@(posedge CLK) disable iff (RST)
        (state == ISSUE) |-> req_valid[w_idx]);

endmodule
